// File: rtl/warp_scheduler_pkg.sv
// Shared types for the warp scheduler: the per-warp pipeline state seen by
// reg_file/ALU/LSU, and the core data width.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package warp_scheduler_pkg;

    localparam int DATA_WIDTH = `DATA_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping
// modulo N. Purely combinational; the caller owns and advances the pointer.
module warp_scheduler_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             grant_valid,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        grant_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!grant_valid && req[(int'(ptr) + i) % N]) begin
                grant_valid                  = 1'b1;
                grant[(int'(ptr) + i) % N]   = 1'b1;
                grant_idx                    = IDX_W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: owns each warp's PC and pipeline state, shares one
// instruction-fetch port among warps round-robin, and flags kernel completion.
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS  = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int WARP_IDX_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [WARP_IDX_W:0]                    num_warps,
    input  logic [DATA_WIDTH-1:0]                  base_pc,
    output logic                                   fetch_req_valid,
    input  logic                                   fetch_req_ready,
    output logic [WARP_IDX_W-1:0]                  fetch_req_warp,
    output logic [DATA_WIDTH-1:0]                  fetch_req_pc,
    input  logic                                   fetch_resp_valid,
    input  logic [NUM_WARPS-1:0]                   lsu_busy,
    input  logic [NUM_WARPS-1:0]                   decoded_ret,
    input  logic [NUM_WARPS-1:0][DATA_WIDTH-1:0]   next_pc,
    output warp_state_t [NUM_WARPS-1:0]            warp_state,
    output logic [NUM_WARPS-1:0]                   warp_enable,
    output logic [NUM_WARPS-1:0][DATA_WIDTH-1:0]   warp_pc,
    output logic                                   done
);

    localparam int CNT_W = WARP_IDX_W + 1;

    warp_state_t [NUM_WARPS-1:0] state_q, state_d;
    logic                        fetch_outstanding_q;
    logic [WARP_IDX_W-1:0]       rr_ptr_q;
    logic [CNT_W-1:0]            launch_cnt;
    logic                        start_accept, any_active, all_enabled_done, resp_fire;
    logic [NUM_WARPS-1:0]        fetch_wants;
    logic                        grant_valid;
    logic [NUM_WARPS-1:0]        grant_onehot;
    logic [WARP_IDX_W-1:0]       grant_idx;
    logic [DATA_WIDTH-1:0]       grant_pc;

    assign warp_state = state_q;
    assign launch_cnt = (num_warps > CNT_W'(NUM_WARPS)) ? CNT_W'(NUM_WARPS) : num_warps;
    assign start_accept = start && !any_active;
    assign resp_fire = fetch_resp_valid && fetch_outstanding_q;

    always_comb begin
        fetch_wants      = '0;
        any_active       = 1'b0;
        all_enabled_done = |warp_enable;
        grant_pc         = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            fetch_wants[w] = (state_q[w] == WARP_FETCH);
            if (state_q[w] != WARP_IDLE && state_q[w] != WARP_DONE) any_active = 1'b1;
            if (warp_enable[w] && state_q[w] != WARP_DONE) all_enabled_done = 1'b0;
            if (grant_onehot[w]) grant_pc = grant_pc | warp_pc[w];
        end
    end

    warp_scheduler_rr_arbiter #(
        .N     (NUM_WARPS),
        .IDX_W (WARP_IDX_W)
    ) u_fetch_arb (
        .req         (fetch_wants),
        .ptr         (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant       (grant_onehot),
        .grant_idx   (grant_idx)
    );

    // Per-warp next state. A launch can only be accepted when no warp is
    // mid-pipeline, so it never collides with the transitions below.
    always_comb begin
        state_d = state_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            case (state_q[w])
                WARP_FETCH:   if (resp_fire && fetch_req_warp == WARP_IDX_W'(w)) state_d[w] = WARP_DECODE;
                WARP_DECODE:  state_d[w] = WARP_REQUEST;
                WARP_REQUEST: state_d[w] = WARP_WAIT;
                WARP_WAIT:    if (!lsu_busy[w]) state_d[w] = WARP_EXECUTE;
                WARP_EXECUTE: state_d[w] = WARP_UPDATE;
                WARP_UPDATE:  state_d[w] = decoded_ret[w] ? WARP_DONE : WARP_FETCH;
                default:      state_d[w] = state_q[w];
            endcase
            if (start_accept) state_d[w] = (CNT_W'(w) < launch_cnt) ? WARP_FETCH : WARP_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) state_q[w] <= WARP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            warp_pc     <= '0;
            warp_enable <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (start_accept) begin
                    warp_enable[w] <= (CNT_W'(w) < launch_cnt);
                    if (CNT_W'(w) < launch_cnt) warp_pc[w] <= base_pc;
                end else if (state_q[w] == WARP_UPDATE && !decoded_ret[w]) begin
                    warp_pc[w] <= next_pc[w];
                end
            end
        end
    end

    // Fetch port: valid/payload are registered and held stable until the
    // valid&&ready handshake; the handshake marks the request outstanding and
    // the next fetch_resp_valid completes it. One request in flight at most.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_req_valid     <= 1'b0;
            fetch_req_warp      <= '0;
            fetch_req_pc        <= '0;
            fetch_outstanding_q <= 1'b0;
            rr_ptr_q            <= '0;
        end else begin
            if (fetch_req_valid && fetch_req_ready) begin
                fetch_req_valid     <= 1'b0;
                fetch_outstanding_q <= 1'b1;
            end else if (!fetch_req_valid && !fetch_outstanding_q && grant_valid) begin
                fetch_req_valid <= 1'b1;
                fetch_req_warp  <= grant_idx;
                fetch_req_pc    <= grant_pc;
            end
            if (resp_fire) begin
                fetch_outstanding_q <= 1'b0;
                rr_ptr_q <= (fetch_req_warp == WARP_IDX_W'(NUM_WARPS - 1)) ? '0
                                                                          : fetch_req_warp + WARP_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
        end else if (start_accept) begin
            done <= (launch_cnt == '0);
        end else if (all_enabled_done) begin
            done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: a scripted fetcher and LSU/decoder
// responder drive the DUT; outputs are sampled on the falling edge.
module tb_warp_scheduler;
  import warp_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] num_warps = '0;
  logic [31:0] base_pc = '0;
  logic fetch_req_valid;
  logic fetch_req_ready = 1'b1;
  logic [1:0] fetch_req_warp;
  logic [31:0] fetch_req_pc;
  logic fetch_resp_valid = 1'b0;
  logic [3:0] lsu_busy = '0;
  logic [3:0] decoded_ret = '0;
  logic [3:0][31:0] next_pc = '0;
  warp_state_t [3:0] warp_state;
  logic [3:0] warp_enable;
  logic [3:0][31:0] warp_pc;
  logic done;

  warp_scheduler #(.NUM_WARPS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .num_warps(num_warps), .base_pc(base_pc),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_req_warp(fetch_req_warp), .fetch_req_pc(fetch_req_pc),
    .fetch_resp_valid(fetch_resp_valid), .lsu_busy(lsu_busy), .decoded_ret(decoded_ret),
    .next_pc(next_pc), .warp_state(warp_state), .warp_enable(warp_enable),
    .warp_pc(warp_pc), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [2:0] exp_q[$];
  logic [2:0] trace_q[$];
  logic [1:0] hs_warp_q[$];
  logic [31:0] hs_pc_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // fetcher model: optional ready stall, response fr_lat cycles after handshake
  int fr_lat = 1;
  int fr_cnt = 0;
  int fr_stall = 0;
  bit fr_out = 1'b0;
  bit fr_stall_seen = 1'b0;
  bit stray_req = 1'b0;
  logic [1:0] stall_warp;
  logic [31:0] stall_pc;

  always @(negedge clk) begin
    fetch_resp_valid = 1'b0;
    fetch_req_ready = 1'b1;
    if (reset) begin
      fr_cnt = 0;
      fr_out = 1'b0;
    end else begin
      if (fr_cnt > 0) begin
        fr_cnt--;
        if (fr_cnt == 0) begin
          fetch_resp_valid = 1'b1;
          fr_out = 1'b0;
        end
      end
      if (fetch_req_valid) begin
        if (fr_stall > 0) begin
          fetch_req_ready = 1'b0;
          fr_stall--;
          if (!fr_stall_seen) begin
            fr_stall_seen = 1'b1;
            stall_warp = fetch_req_warp;
            stall_pc = fetch_req_pc;
          end else begin
            check("stall_warp_stable", fetch_req_warp, stall_warp);
            check("stall_pc_stable", fetch_req_pc, stall_pc);
          end
        end
        if (fetch_req_ready) begin
          if (fr_stall_seen) begin
            check("release_warp_stable", fetch_req_warp, stall_warp);
            fr_stall_seen = 1'b0;
          end
          check("single_outstanding", fr_out, 1'b0);
          hs_warp_q.push_back(fetch_req_warp);
          hs_pc_q.push_back(fetch_req_pc);
          fr_out = 1'b1;
          fr_cnt = fr_lat;
        end
      end
    end
    if (stray_req) begin
      fetch_resp_valid = 1'b1;
      stray_req = 1'b0;
    end
  end

  // LSU / decoder model: RET on the ret_at-th UPDATE, WAIT lasts wait_tgt cycles
  int ret_at[4] = '{1, 1, 1, 1};
  int wait_tgt[4] = '{1, 1, 1, 1};
  int upd_cnt[4] = '{0, 0, 0, 0};
  int wait_cnt[4] = '{0, 0, 0, 0};
  int wait_max[4] = '{0, 0, 0, 0};
  bit overlap = 1'b0;

  always @(negedge clk) begin
    for (int w = 0; w < 4; w++) begin
      next_pc[w] = warp_pc[w] + 32'd1;
      decoded_ret[w] = 1'b0;
      if (warp_state[w] == WARP_IDLE || warp_state[w] == WARP_DONE) upd_cnt[w] = 0;
      if (warp_state[w] == WARP_UPDATE) begin
        upd_cnt[w]++;
        decoded_ret[w] = (upd_cnt[w] == ret_at[w]);
      end
      if (warp_state[w] == WARP_WAIT) begin
        wait_cnt[w]++;
        if (wait_cnt[w] > wait_max[w]) wait_max[w] = wait_cnt[w];
        lsu_busy[w] = (wait_cnt[w] < wait_tgt[w]);
      end else begin
        wait_cnt[w] = 0;
        lsu_busy[w] = (wait_tgt[w] > 1);
      end
    end
    if (warp_state[0] == WARP_UPDATE && warp_state[1] == WARP_WAIT) overlap = 1'b1;
  end

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic launch(input logic [2:0] n, input logic [31:0] pc);
    num_warps = n;
    base_pc = pc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    for (int w = 0; w < 4; w++) begin
      check({tag, "_state"}, warp_state[w], WARP_IDLE);
      check({tag, "_pc"}, warp_pc[w], 32'h0);
    end
    check({tag, "_enable"}, warp_enable, 4'h0);
    check({tag, "_valid"}, fetch_req_valid, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    int k;
    int w0_cyc, w1_cyc, done_cyc;
    bit seen, early;
    logic [31:0] w1_pcs[$];

    do_reset();
    check_reset_values("rst");

    // three warps fetch at once; first request stalled 3 cycles
    fr_lat = 1;
    fr_stall = 3;
    hs_warp_q.delete();
    hs_pc_q.delete();
    launch(3'd3, 32'h20);
    check("t2_enable", warp_enable, 4'b0111);
    wait_done("t2_done", 200);
    check("t2_grants", hs_warp_q.size(), 3);
    for (int i = 0; i < 3 && i < hs_warp_q.size(); i++) begin
      check("t2_grant_order", hs_warp_q[i], i);
      check("t2_grant_pc", hs_pc_q[i], 32'h20);
    end

    // single warp, two instructions, RET on the second
    do_reset();
    fr_lat = 2;
    ret_at[0] = 2;
    hs_warp_q.delete();
    hs_pc_q.delete();
    exp_q.delete();
    trace_q.delete();
    for (int r = 0; r < 2; r++) begin
      repeat (4) exp_q.push_back(WARP_FETCH);
      exp_q.push_back(WARP_DECODE);
      exp_q.push_back(WARP_REQUEST);
      exp_q.push_back(WARP_WAIT);
      exp_q.push_back(WARP_EXECUTE);
      exp_q.push_back(WARP_UPDATE);
    end
    exp_q.push_back(WARP_DONE);
    launch(3'd1, 32'h10);
    k = 0;
    while (k < 40) begin
      trace_q.push_back(warp_state[0]);
      if (warp_state[0] == WARP_DONE) break;
      @(negedge clk);
      k++;
    end
    check("t1_trace_len", trace_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < trace_q.size(); i++)
      check("t1_trace_state", trace_q[i], exp_q[i]);
    check("t1_done_low_in_done", done, 1'b0);
    @(negedge clk);
    check("t1_done_next", done, 1'b1);
    check("t1_fetches", hs_pc_q.size(), 2);
    if (hs_pc_q.size() >= 2) begin
      check("t1_pc0", hs_pc_q[0], 32'h10);
      check("t1_pc1", hs_pc_q[1], 32'h11);
    end
    check("t1_final_pc", warp_pc[0], 32'h11);
    ret_at[0] = 1;

    // warp1 held in WAIT by lsu_busy while warp0 reaches UPDATE
    do_reset();
    fr_lat = 1;
    wait_tgt[0] = 3;
    wait_tgt[1] = 5;
    overlap = 1'b0;
    wait_max = '{0, 0, 0, 0};
    launch(3'd2, 32'h30);
    wait_done("t3_done", 200);
    check("t3_w1_wait_len", wait_max[1], 5);
    check("t3_w0_wait_len", wait_max[0], 3);
    check("t3_overlap", overlap, 1'b1);
    wait_tgt[0] = 1;
    wait_tgt[1] = 1;

    // empty launch, then a start while a warp is mid-run
    do_reset();
    hs_warp_q.delete();
    hs_pc_q.delete();
    launch(3'd0, 32'h50);
    check("t4_zero_done", done, 1'b1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= fetch_req_valid;
    end
    check("t4_zero_no_valid", seen, 1'b0);
    check("t4_zero_enable", warp_enable, 4'h0);
    fr_lat = 2;
    wait_tgt[0] = 4;
    launch(3'd1, 32'h40);
    check("t4_done_cleared", done, 1'b0);
    k = 0;
    while (warp_state[0] != WARP_WAIT && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("t4_reach_wait", warp_state[0], WARP_WAIT);
    launch(3'd2, 32'h80);
    check("t4_ignored_enable", warp_enable, 4'b0001);
    check("t4_ignored_pc0", warp_pc[0], 32'h40);
    check("t4_ignored_w1", warp_state[1], WARP_IDLE);
    wait_done("t4_done", 100);
    check("t4_final_pc", warp_pc[0], 32'h40);
    check("t4_fetches", hs_pc_q.size(), 1);
    wait_tgt[0] = 1;

    // reset mid-run with a fetch outstanding, then a stray response
    do_reset();
    fr_lat = 6;
    wait_tgt[0] = 20;
    launch(3'd2, 32'h60);
    k = 0;
    while (!(warp_state[0] == WARP_WAIT && fr_out) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t5_setup", (warp_state[0] == WARP_WAIT) && fr_out, 1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_tgt[0] = 1;
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("t5_after");

    // warp0 returns first, warp1 runs three more instructions
    fr_lat = 1;
    ret_at[1] = 4;
    hs_warp_q.delete();
    hs_pc_q.delete();
    launch(3'd2, 32'h100);
    w0_cyc = -1;
    w1_cyc = -1;
    done_cyc = -1;
    early = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (warp_state[0] == WARP_DONE && w0_cyc < 0) w0_cyc = c;
      if (warp_state[1] == WARP_DONE && w1_cyc < 0) w1_cyc = c;
      if (done && warp_state[1] != WARP_DONE) early = 1'b1;
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    check("t6_done", done, 1'b1);
    check("t6_no_early_done", early, 1'b0);
    check("t6_w0_first", (w0_cyc >= 0) && (w0_cyc < w1_cyc), 1'b1);
    check("t6_done_latency", done_cyc - w1_cyc, 1);
    w1_pcs.delete();
    for (int i = 0; i < hs_warp_q.size(); i++)
      if (hs_warp_q[i] == 2'd1) w1_pcs.push_back(hs_pc_q[i]);
    check("t6_w1_fetches", w1_pcs.size(), 4);
    for (int i = 0; i < 4 && i < w1_pcs.size(); i++)
      check("t6_w1_pc", w1_pcs[i], 32'h100 + i);
    check("t6_total_fetches", hs_warp_q.size(), 5);
    ret_at[1] = 1;

    // oversized warp count clamps to four warps
    do_reset();
    fr_lat = 1;
    hs_warp_q.delete();
    hs_pc_q.delete();
    launch(3'd7, 32'h200);
    check("t7_clamp_enable", warp_enable, 4'hF);
    wait_done("t7_done", 300);
    check("t7_grants", hs_warp_q.size(), 4);
    for (int i = 0; i < 4 && i < hs_warp_q.size(); i++)
      check("t7_grant_order", hs_warp_q[i], i);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
